// File: rtl/stream_src_pkg.sv
// stream_src_pkg: shared FSM state encoding and default widths for stream_src
package stream_src_pkg;
    localparam int DEF_DW = 8;
    localparam int DEF_CW = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: clearable up-counter that sticks at its all-ones value
module sat_cnt
    import stream_src_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/stream_src.sv
// stream_src: arithmetic-sequence burst source with req/ack handshake, abort and stall counting
module stream_src
    import stream_src_pkg::*;
#(
    parameter int dw = DEF_DW,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [dw-1:0] base,
    input  logic [dw-1:0] step,
    input  logic [CW-1:0] len,
    input  logic          abort,
    output logic [dw-1:0] d_out,
    output logic          req_out,
    input  logic          ack_out,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [CW-1:0] sent,
    output logic [CW-1:0] stall_cnt
);
    state_t        state, state_nx;
    logic [dw-1:0] step_q, step_nx, d_nx;
    logic [CW-1:0] rem, rem_nx, sent_nx;
    logic          req_nx, ab_nx, xfer;
    assign xfer = req_out && ack_out;
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            step_q  <= '0;
            rem     <= '0;
            d_out   <= '0;
            req_out <= 1'b0;
            aborted <= 1'b0;
            sent    <= '0;
        end else begin
            state   <= state_nx;
            step_q  <= step_nx;
            rem     <= rem_nx;
            d_out   <= d_nx;
            req_out <= req_nx;
            aborted <= ab_nx;
            sent    <= sent_nx;
        end
    always_comb begin
        state_nx = state;
        step_nx  = step_q;
        rem_nx   = rem;
        d_nx     = d_out;
        req_nx   = req_out;
        ab_nx    = aborted;
        sent_nx  = sent;
        case (state)
            IDLE:
                if (start) begin
                    sent_nx = '0;
                    ab_nx   = 1'b0;
                    if (len != '0) begin
                        d_nx     = base;
                        step_nx  = step;
                        rem_nx   = len;
                        req_nx   = 1'b1;
                        state_nx = SEND;
                    end else begin
                        state_nx = DONE;
                    end
                end
            SEND: begin
                if (xfer) begin
                    d_nx    = d_out + step_q;
                    sent_nx = sent + 1'b1;
                    rem_nx  = rem - 1'b1;
                end
                // a transfer in the abort cycle is still counted above
                if (abort || (xfer && rem == CW'(1))) begin
                    req_nx   = 1'b0;
                    ab_nx    = abort;
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    sat_cnt #(.CW(CW)) u_stall (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE && start),
        .inc  (state == SEND && req_out && !ack_out),
        .count(stall_cnt)
    );
endmodule

// File: tb/tb_stream_src.sv
// tb_stream_src: directed and randomized checks of stream_src against a burst-level reference model
module tb_stream_src;
    logic       clk = 1'b0;
    logic       rst, start, abort, ack_out;
    logic [7:0] base, step, len;
    logic [7:0] d_out, sent, stall_cnt;
    logic       req_out, busy, done, aborted;
    int checks = 0;
    int failures = 0;
    bit m_act, m_fin, m_ab;
    int m_sent, m_stall, m_len;
    logic [7:0] m_base, m_step, m_d;
    always #5 clk = ~clk;
    stream_src dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .step(step), .len(len),
        .abort(abort), .d_out(d_out), .req_out(req_out), .ack_out(ack_out),
        .busy(busy), .done(done), .aborted(aborted), .sent(sent), .stall_cnt(stall_cnt)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_act = 0; m_fin = 0; m_ab = 0;
        m_sent = 0; m_stall = 0; m_len = 0;
        m_base = 0; m_step = 0; m_d = 0;
    endtask
    // word i of a burst is base + i*step; sent words determine the current word
    task automatic model_edge();
        if (m_fin) m_fin = 0;
        else if (m_act) begin
            if (ack_out) begin
                m_sent++;
                m_d = 8'(m_base + m_sent * m_step);
            end else if (m_stall < 255) m_stall++;
            if (abort) begin
                m_act = 0; m_fin = 1; m_ab = 1;
            end else if (ack_out && m_sent == m_len) begin
                m_act = 0; m_fin = 1;
            end
        end else if (start) begin
            m_sent = 0; m_stall = 0; m_ab = 0;
            if (len != 0) begin
                m_base = base; m_step = step; m_len = len; m_d = base; m_act = 1;
            end else m_fin = 1;
        end
    endtask
    task automatic check_all();
        chk("d_out", d_out, m_d);
        chk("req_out", req_out, m_act);
        chk("busy", busy, m_act | m_fin);
        chk("done", done, m_fin);
        chk("aborted", aborted, m_ab);
        chk("sent", sent, m_sent);
        chk("stall_cnt", stall_cnt, m_stall);
    endtask
    task automatic cyc(input logic s, input logic a, input logic k,
                       input logic [7:0] b, input logic [7:0] st, input logic [7:0] l);
        start = s; abort = a; ack_out = k; base = b; step = st; len = l;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask
    task automatic idle(input logic k);
        cyc(0, 0, k, 8'h0, 8'h0, 8'h0);
    endtask
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_d_out", d_out, 0);
        chk("rst_req", req_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_sent", sent, 0);
        chk("rst_stall", stall_cnt, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask
    initial begin
        rst = 1'b1; start = 0; abort = 0; ack_out = 0; base = 0; step = 0; len = 0;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        idle(1);
        cyc(1, 0, 1, 8'h10, 8'h01, 8'd3);
        chk("b1_w0", d_out, 8'h10);
        idle(1);
        chk("b1_w1", d_out, 8'h11);
        idle(1);
        chk("b1_w2", d_out, 8'h12);
        idle(1);
        chk("b1_done", done, 1);
        chk("b1_sent", sent, 3);
        chk("b1_stall", stall_cnt, 0);
        idle(1);
        cyc(1, 0, 0, 8'h00, 8'h05, 8'd4);
        for (int i = 0; i < 4; i++) begin
            chk("b2_hold", d_out, 8'h00);
            idle(0);
        end
        idle(1);
        chk("b2_w1", d_out, 8'h05);
        idle(1);
        chk("b2_w2", d_out, 8'h0A);
        idle(1);
        chk("b2_w3", d_out, 8'h0F);
        idle(1);
        chk("b2_done", done, 1);
        chk("b2_stall", stall_cnt, 4);
        idle(1);
        cyc(1, 0, 1, 8'hFE, 8'h01, 8'd3);
        chk("b3_w0", d_out, 8'hFE);
        idle(1);
        chk("b3_w1", d_out, 8'hFF);
        idle(1);
        chk("b3_w2", d_out, 8'h00);
        idle(1);
        idle(1);
        cyc(1, 0, 1, 8'h55, 8'h01, 8'd0);
        chk("b4_req", req_out, 0);
        chk("b4_done", done, 1);
        chk("b4_sent", sent, 0);
        idle(1);
        chk("b4_req_after", req_out, 0);
        cyc(1, 0, 1, 8'h20, 8'h02, 8'd10);
        idle(1);
        idle(1);
        cyc(0, 1, 1, 8'h0, 8'h0, 8'h0);
        chk("b5_sent", sent, 3);
        chk("b5_req", req_out, 0);
        chk("b5_done", done, 1);
        chk("b5_aborted", aborted, 1);
        idle(1);
        cyc(1, 0, 1, 8'h00, 8'h01, 8'd5);
        idle(1);
        async_reset();
        idle(1);
        chk("b6_no_done", done, 0);
        cyc(1, 0, 1, 8'h03, 8'h01, 8'd5);
        for (int i = 0; i < 5; i++) idle(1);
        chk("b6_done", done, 1);
        chk("b6_sent", sent, 5);
        idle(1);
        cyc(1, 0, 0, 8'h40, 8'h01, 8'd2);
        for (int i = 0; i < 300; i++) idle(0);
        chk("sat_stall", stall_cnt, 255);
        idle(1);
        idle(1);
        idle(1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            else cyc($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                     8'($urandom_range(0, 7)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
